// File: rtl/fetch_unit.sv
// Instruction fetch front end: PC register feeding a 2-entry {pc, instr} FIFO
// toward decode, with execute-driven redirect/flush and a misalignment flag.
module fetch_unit #(
    parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
    input  logic        clk,
    input  logic        rst,
    output logic [31:0] imem_addr,
    input  logic [31:0] imem_instr,
    input  logic        redirect_valid,
    input  logic [31:0] redirect_target,
    output logic        out_valid,
    input  logic        out_ready,
    output logic [31:0] out_instr,
    output logic [31:0] out_pc,
    output logic [31:0] out_pc_plus4,
    output logic        misalign_err,
    output logic [31:0] fetch_count
);

    typedef struct packed {
        logic [31:0] pc;
        logic [31:0] instr;
    } entry_t;

    entry_t      head, tail, new_entry;
    logic [1:0]  count;
    logic [31:0] pc;
    logic        push, pop;

    assign imem_addr    = pc;
    assign new_entry    = '{pc: pc, instr: imem_instr};
    assign out_valid    = (count != 2'd0);
    assign out_pc       = head.pc;
    assign out_instr    = head.instr;
    assign out_pc_plus4 = head.pc + 32'd4;

    assign pop  = out_valid & out_ready;
    assign push = ~redirect_valid & ((count != 2'd2) | pop);

    always_ff @(posedge clk) begin
        if (rst) begin
            pc           <= RESET_PC;
            count        <= 2'd0;
            fetch_count  <= 32'd0;
            misalign_err <= 1'b0;
        end else begin
            misalign_err <= redirect_valid & (|redirect_target[1:0]);
            if (redirect_valid) begin
                // A same-cycle pop still handshakes; the flush then drops everything.
                pc    <= {redirect_target[31:2], 2'b00};
                count <= 2'd0;
            end else begin
                if (push) begin
                    pc          <= pc + 32'd4;
                    fetch_count <= fetch_count + 32'd1;
                end
                case ({push, pop})
                    2'b10:   count <= count + 2'd1;
                    2'b01:   count <= count - 2'd1;
                    default: count <= count;
                endcase
            end
        end
    end

    // Data storage needs no reset; occupancy alone decides what is live.
    always_ff @(posedge clk) begin
        if (push) begin
            if (count == 2'd0 || (count == 2'd1 && pop)) begin
                head <= new_entry;
            end else if (count == 2'd1) begin
                tail <= new_entry;
            end else begin
                head <= tail;
                tail <= new_entry;
            end
        end else if (pop && count == 2'd2) begin
            head <= tail;
        end
    end

endmodule

// File: tb/tb_fetch_unit.sv
// Scoreboard bench for fetch_unit: stimulus queues expected {pc, instr} entries,
// a negedge monitor pops and compares on every decode handshake.
module tb_fetch_unit;

    typedef struct packed {
        logic [31:0] pc;
        logic [31:0] instr;
    } exp_t;

    logic        clk = 1'b0;
    logic        rst;
    logic        redirect_valid;
    logic [31:0] redirect_target;
    logic        out_ready;

    logic [31:0] a_addr, a_instr_in, a_instr, a_pc, a_pc4, a_fc;
    logic        a_valid, a_mis;
    logic [31:0] b_addr, b_instr_in, b_instr, b_pc, b_pc4, b_fc;
    logic        b_valid, b_mis;

    logic        sel;
    logic        chk_en;
    logic        m_valid;
    logic [31:0] m_pc, m_pc4, m_instr;
    exp_t        exp_q[$];
    exp_t        exp_e;
    int          tests = 0;
    int          fails = 0;

    always #5 clk = ~clk;

    // Instruction memory: word i holds 32'h1000_0000 + i.
    assign a_instr_in = 32'h1000_0000 + {2'b00, a_addr[31:2]};
    assign b_instr_in = 32'h1000_0000 + {2'b00, b_addr[31:2]};

    fetch_unit #(.RESET_PC(32'h0000_0000)) dut_a (
        .clk(clk), .rst(rst), .imem_addr(a_addr), .imem_instr(a_instr_in),
        .redirect_valid(redirect_valid), .redirect_target(redirect_target),
        .out_valid(a_valid), .out_ready(out_ready), .out_instr(a_instr),
        .out_pc(a_pc), .out_pc_plus4(a_pc4), .misalign_err(a_mis), .fetch_count(a_fc)
    );

    fetch_unit #(.RESET_PC(32'hFFFF_FFF8)) dut_b (
        .clk(clk), .rst(rst), .imem_addr(b_addr), .imem_instr(b_instr_in),
        .redirect_valid(redirect_valid), .redirect_target(redirect_target),
        .out_valid(b_valid), .out_ready(out_ready), .out_instr(b_instr),
        .out_pc(b_pc), .out_pc_plus4(b_pc4), .misalign_err(b_mis), .fetch_count(b_fc)
    );

    always_comb begin
        m_valid = sel ? b_valid : a_valid;
        m_pc    = sel ? b_pc    : a_pc;
        m_pc4   = sel ? b_pc4   : a_pc4;
        m_instr = sel ? b_instr : a_instr;
    end

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic exp_push(input logic [31:0] pc, input logic [31:0] instr);
        exp_q.push_back('{pc: pc, instr: instr});
    endtask

    task automatic drain(input string name);
        for (int i = 0; i < 50; i++) begin
            if (exp_q.size() == 0) break;
            @(posedge clk);
        end
        chk({name, "_drain_left"}, exp_q.size(), 32'd0);
        exp_q.delete();
        chk_en = 1'b0;
    endtask

    always @(negedge clk) begin
        if (chk_en && m_valid && out_ready) begin
            if (exp_q.size() == 0) begin
                tests++;
                fails++;
                $display("FAIL extra_pop: got pc %h with nothing expected", m_pc);
            end else begin
                exp_e = exp_q.pop_front();
                chk("sb_pc", m_pc, exp_e.pc);
                chk("sb_instr", m_instr, exp_e.instr);
                chk("sb_pc_plus4", m_pc4, exp_e.pc + 32'd4);
            end
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "timeout");
    end

    initial begin
        rst = 1'b1; out_ready = 1'b1; redirect_valid = 1'b0;
        redirect_target = 32'h0; sel = 1'b0; chk_en = 1'b0;

        // Reset state, then full-rate streaming from address 0.
        repeat (2) @(posedge clk);
        @(negedge clk);
        chk("rst_out_valid", a_valid, 32'd0);
        chk("rst_imem_addr", a_addr, 32'h0);
        chk("rst_fetch_count", a_fc, 32'd0);
        chk("rst_misalign", a_mis, 32'd0);
        for (int i = 0; i < 8; i++) exp_push(32'(4 * i), 32'h1000_0000 + 32'(i));
        chk_en = 1'b1;
        @(posedge clk); #1 rst = 1'b0;
        drain("stream");

        // Backpressure right after reset: FIFO saturates at two entries.
        @(posedge clk); #1 rst = 1'b1; out_ready = 1'b0;
        @(posedge clk); #1 rst = 1'b0;
        repeat (5) @(posedge clk);
        @(negedge clk);
        chk("bp_imem_addr", a_addr, 32'h8);
        chk("bp_fetch_count", a_fc, 32'd2);
        chk("bp_out_valid", a_valid, 32'd1);
        exp_push(32'h0, 32'h1000_0000);
        exp_push(32'h4, 32'h1000_0001);
        exp_push(32'h8, 32'h1000_0002);
        exp_push(32'hC, 32'h1000_0003);
        chk_en = 1'b1;
        @(posedge clk); #1 out_ready = 1'b1;
        drain("bp");

        // Redirect while full.
        @(posedge clk); #1 out_ready = 1'b0;
        repeat (3) @(posedge clk);
        #1 redirect_valid = 1'b1; redirect_target = 32'h0000_0040;
        @(posedge clk); #1 redirect_valid = 1'b0; out_ready = 1'b1;
        exp_push(32'h40, 32'h1000_0010);
        exp_push(32'h44, 32'h1000_0011);
        exp_push(32'h48, 32'h1000_0012);
        chk_en = 1'b1;
        @(negedge clk);
        chk("redir_out_valid", a_valid, 32'd0);
        chk("redir_imem_addr", a_addr, 32'h40);
        chk("redir_misalign", a_mis, 32'd0);
        @(negedge clk);
        chk("redir_out_pc", a_pc, 32'h40);
        chk("redir_out_pc4", a_pc4, 32'h44);
        drain("redir");

        // Misaligned redirect target.
        @(posedge clk); #1 redirect_valid = 1'b1; redirect_target = 32'h0000_0043;
        @(posedge clk); #1 redirect_valid = 1'b0;
        @(negedge clk);
        chk("mis_pulse", a_mis, 32'd1);
        chk("mis_imem_addr", a_addr, 32'h40);
        chk("mis_out_valid", a_valid, 32'd0);
        @(negedge clk);
        chk("mis_clear", a_mis, 32'd0);

        // Back-to-back redirects: the last target wins.
        @(posedge clk); #1 redirect_valid = 1'b1; redirect_target = 32'h0000_0100;
        @(posedge clk); #1 redirect_target = 32'h0000_0204;
        @(posedge clk); #1 redirect_valid = 1'b0;
        exp_push(32'h204, 32'h1000_0081);
        exp_push(32'h208, 32'h1000_0082);
        exp_push(32'h20C, 32'h1000_0083);
        chk_en = 1'b1;
        @(negedge clk);
        chk("b2b_imem_addr", a_addr, 32'h204);
        chk("b2b_out_valid", a_valid, 32'd0);
        drain("b2b");

        // Reset dominates a simultaneous misaligned redirect while full.
        @(posedge clk); #1 out_ready = 1'b0;
        repeat (3) @(posedge clk);
        #1 rst = 1'b1; redirect_valid = 1'b1; redirect_target = 32'h0000_0043;
        @(posedge clk); #1 rst = 1'b0; redirect_valid = 1'b0;
        @(negedge clk);
        chk("rstdom_out_valid", a_valid, 32'd0);
        chk("rstdom_imem_addr", a_addr, 32'h0);
        chk("rstdom_fetch_count", a_fc, 32'd0);
        chk("rstdom_misalign", a_mis, 32'd0);

        // PC wrap from a high reset address.
        @(posedge clk); #1 rst = 1'b1; out_ready = 1'b1;
        @(posedge clk); #1
        exp_push(32'hFFFF_FFF8, 32'h4FFF_FFFE);
        exp_push(32'hFFFF_FFFC, 32'h4FFF_FFFF);
        exp_push(32'h0000_0000, 32'h1000_0000);
        exp_push(32'h0000_0004, 32'h1000_0001);
        sel = 1'b1; chk_en = 1'b1; rst = 1'b0;
        drain("wrap");

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule

// File: doc/fetch_unit.md
FETCH_UNIT -- requirements
Module: fetch_unit

Interface
REQ-001 Parameter RESET_PC, default 32'h0000_0000, PC value loaded on reset; bits [1:0] SHALL be 0.
REQ-002 clk  input  1  single clock; all state updates on rising edge.
REQ-003 rst  input  1  reset, synchronous and active-high.
REQ-004 imem_addr  output  32  byte address presented to instruction memory; equals current PC.
REQ-005 imem_instr  input  32  instruction word returned combinationally by instruction memory for imem_addr, valid in the same cycle.
REQ-006 redirect_valid  input  1  branch/jump redirect request from execute.
REQ-007 redirect_target  input  32  new fetch address when redirect_valid=1.
REQ-008 out_valid  output  1  decode-side entry available.
REQ-009 out_ready  input  1  decode accepts the entry this cycle.
REQ-010 out_instr  output  32  instruction word of head entry.
REQ-011 out_pc  output  32  PC of head entry.
REQ-012 out_pc_plus4  output  32  out_pc + 4, modulo 2^32.
REQ-013 misalign_err  output  1  one-cycle pulse: accepted redirect target had bits [1:0] != 0.
REQ-014 fetch_count  output  32  number of entries pushed since reset.

Function
REQ-015 State: PC register (32 b), 2-entry FIFO of {pc, instr}, occupancy count 0..2, fetch_count register, misalign_err register.
REQ-016 imem_addr SHALL equal PC combinationally; no other address source.
REQ-017 pop = out_valid & out_ready; out_valid = (count != 0); out_* SHALL reflect head entry, registered (no combinational path from imem_instr to out_*).
REQ-018 push = ~redirect_valid & ((count < 2) | pop); on push, entry {PC, imem_instr} is written at tail and PC <= PC + 4 (wraps 32'hFFFF_FFFC -> 32'h0000_0000).
REQ-019 No push while count=2 and no pop: PC holds, FIFO holds, imem_addr stable.
REQ-020 Full and pop same cycle: head removed, new entry pushed, count stays 2.
REQ-021 Empty and push: entry visible on out_* next cycle (fetch-to-decode latency exactly 1 cycle).
REQ-022 Push and pop with count=1: count stays 1; new entry becomes head next cycle.
REQ-023 Redirect (redirect_valid=1): FIFO flushed (count <= 0), PC <= {redirect_target[31:2], 2'b00}, no push that cycle; a pop in the same cycle completes its handshake, then the entry is discarded by the flush.
REQ-024 misalign_err SHALL be 1 for exactly the cycle after a redirect with redirect_target[1:0] != 0, else 0.
REQ-025 fetch_count increments by 1 on each push, wraps mod 2^32; unaffected by redirect.
REQ-026 Back-to-back redirects: each redirect overrides; the last cycle's target wins, fetching resumes the cycle after redirect_valid falls.
REQ-027 Throughput: with out_ready held high and no redirect, one entry delivered per cycle after the first.

Reset
REQ-028 When rst=1 at a clock edge: PC <= RESET_PC, count <= 0, fetch_count <= 0, misalign_err <= 0; out_valid=0 the following cycle; FIFO data contents unspecified.
REQ-029 rst SHALL dominate redirect_valid, push and pop in the same cycle; reset mid-stream discards all buffered entries.
REQ-030 First push occurs in the first cycle with rst=0, at address RESET_PC.

Verification
REQ-031 Reset, out_ready=1, memory word i = 32'h1000_0000+i -> out_pc 0,4,8,... on consecutive cycles, out_instr 32'h1000_0000, 32'h1000_0001, ..., out_valid high from cycle 2.
REQ-032 out_ready=0 for 5 cycles after reset -> count saturates at 2, imem_addr held at 32'h8, fetch_count=2; release -> entries pc 0, 4, 8 delivered in order, none lost or duplicated.
REQ-033 Redirect to 32'h0000_0040 while FIFO full -> next cycle out_valid=0, imem_addr=32'h40; following cycle out_pc=32'h40, out_pc_plus4=32'h44.
REQ-034 Redirect to 32'h0000_0043 -> misalign_err=1 for one cycle, imem_addr=32'h40.
REQ-035 Reset with RESET_PC=32'hFFFF_FFF8, out_ready=1 -> out_pc FFFF_FFF8, FFFF_FFFC, 0000_0000 (PC wraps).
REQ-036 rst asserted for one cycle while FIFO full and redirect_valid=1 -> out_valid=0, imem_addr=RESET_PC, fetch_count=0, misalign_err=0.
